// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg -- shared opcode/ISA definitions for the 16-bit pipeline.
// Holds the word width, instruction field positions, the opcode list and
// the fetch-stage FSM state encoding, plus small field-extraction helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int WORD_W     = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;
  localparam int FUNC_W     = FUNC_MSB - FUNC_LSB + 1;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [OPCODE_W-1:0] {
    OP_BNE   = 4'd0,
    OP_BEQ   = 4'd1,
    OP_BGZ   = 4'd2,
    OP_BLZ   = 4'd3,
    OP_ADI   = 4'd4,
    OP_ORI   = 4'd5,
    OP_LHI   = 4'd6,
    OP_LWD   = 4'd7,
    OP_SWD   = 4'd8,
    OP_JMP   = 4'd9,
    OP_JAL   = 4'd10,
    OP_RTYPE = 4'd15
  } opcode_t;

  // Fetch FSM encoding; exported on the debug port of fetch_stage.
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic [OPCODE_W-1:0] get_opcode(input word_t w);
    return w[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [FUNC_W-1:0] get_func(input word_t w);
    return w[FUNC_MSB:FUNC_LSB];
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// ---------------------------------------------------------------------------
// fetch_skid_buffer -- one-entry holding register for an instruction word
// (and its PC+1) that arrived from memory while decode was stalled.
// Ports:
//   clk, reset_n        clock / asynchronous active-low reset
//   load                capture data_in/pc_in and mark full
//   clear               discard the entry (wins over load)
//   data_in, pc_in      word and PC+1 to capture
//   data_out, pc_out    stored word and PC+1
//   full                entry holds a pending instruction
// ---------------------------------------------------------------------------
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load,
  input  logic  clear,
  input  word_t data_in,
  input  word_t pc_in,
  output word_t data_out,
  output word_t pc_out,
  output logic  full
);

  word_t data_q, data_d;
  word_t pc_q, pc_d;
  logic  full_q, full_d;

  always_comb begin
    data_d = data_q;
    pc_d   = pc_q;
    full_d = full_q;
    if (clear) begin
      data_d = '0;
      pc_d   = '0;
      full_d = 1'b0;
    end else if (load) begin
      data_d = data_in;
      pc_d   = pc_in;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      pc_q   <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      pc_q   <= pc_d;
      full_q <= full_d;
    end
  end

  assign data_out = data_q;
  assign pc_out   = pc_q;
  assign full     = full_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction fetch stage with IF/ID pipeline register.
// Ports:
//   clk, reset_n          clock / asynchronous active-low reset
//   i_readM, i_address    memory read request and address (always the PC)
//   i_data, i_ready       memory response word and its qualifier
//   stall                 hold IF/ID (load-use hazard in decode)
//   redirect, redirect_pc taken branch/jump: flush and refetch at target
//   halt                  HLT decoded: stop fetching
//   if_id_inst/_pc_next   registered instruction and its PC+1
//   if_id_valid           IF/ID holds a real instruction (0 = bubble)
//   opcode, func_code     fields decoded from if_id_inst
//   fetched_count         instructions loaded into IF/ID (wraps)
//   dbg_state             current FSM state
//   dbg_skid_full         skid buffer holds a pending instruction
//
// Handshake: a request is outstanding whenever i_readM=1; i_data is
// consumed on a rising edge only when i_ready=1 in that cycle. If decode
// is stalling at that moment the word goes to the skid buffer and no
// further request is made until the stall clears.
// ---------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  output logic                i_readM,
  output word_t               i_address,
  input  word_t               i_data,
  input  logic                i_ready,
  input  logic                stall,
  input  logic                redirect,
  input  word_t               redirect_pc,
  input  logic                halt,
  output word_t               if_id_inst,
  output word_t               if_id_pc_next,
  output logic                if_id_valid,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNC_W-1:0]   func_code,
  output word_t               fetched_count,
  output fetch_state_t        dbg_state,
  output logic                dbg_skid_full
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        inst_q, inst_d;
  word_t        pc_next_q, pc_next_d;
  logic         valid_q, valid_d;
  word_t        count_q, count_d;

  logic  skid_load, skid_clear, skid_full;
  word_t skid_data, skid_pc;
  word_t pc_plus_one;

  // 16-bit add: 16'hFFFF rolls over to 16'h0000.
  assign pc_plus_one = pc_q + 16'd1;

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (skid_load),
    .clear    (skid_clear),
    .data_in  (i_data),
    .pc_in    (pc_plus_one),
    .data_out (skid_data),
    .pc_out   (skid_pc),
    .full     (skid_full)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    pc_next_d  = pc_next_q;
    valid_d    = valid_q;
    count_d    = count_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    // redirect beats everything, halt beats normal flow; inst/pc_next are
    // left alone on a flush so only the valid bit marks the bubble.
    if (redirect) begin
      pc_d       = redirect_pc;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      state_d    = ST_FETCH;
    end else if (halt) begin
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      state_d    = ST_HALTED;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (i_ready && !stall) begin
            inst_d    = i_data;
            pc_next_d = pc_plus_one;
            valid_d   = 1'b1;
            pc_d      = pc_plus_one;
            count_d   = count_q + 16'd1;
          end else if (i_ready && stall) begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            inst_d     = skid_data;
            pc_next_d  = skid_pc;
            valid_d    = 1'b1;
            pc_d       = pc_plus_one;
            count_d    = count_q + 16'd1;
            skid_clear = 1'b1;
            state_d    = ST_FETCH;
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      inst_q    <= '0;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign i_readM       = (state_q == ST_FETCH);
  assign i_address     = pc_q;
  assign if_id_inst    = inst_q;
  assign if_id_pc_next = pc_next_q;
  assign if_id_valid   = valid_q;
  assign opcode        = get_opcode(inst_q);
  assign func_code     = get_func(inst_q);
  assign fetched_count = count_q;
  assign dbg_state     = state_q;
  assign dbg_skid_full = skid_full;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 i_readM  output  1  instruction memory read request.
REQ-005 i_address  output  16  instruction memory address (current PC).
REQ-006 i_data  input  16  instruction word; valid only when i_ready=1.
REQ-007 i_ready  input  1  memory response valid for the current request.
REQ-008 stall  input  1  hold IF/ID (load-use hazard from decode).
REQ-009 redirect  input  1  taken branch/jump; flush and refetch.
REQ-010 redirect_pc  input  16  target PC, sampled when redirect=1.
REQ-011 halt  input  1  HLT decoded in ID; stop fetching.
REQ-012 if_id_inst  output  16  registered instruction word.
REQ-013 if_id_pc_next  output  16  registered PC+1 of that instruction.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-015 opcode  output  4  if_id_inst[15:12], combinational.
REQ-016 func_code  output  6  if_id_inst[5:0], combinational.
REQ-017 fetched_count  output  16  number of instructions loaded into IF/ID.

Function
REQ-018 The FSM SHALL have states FETCH, HOLD, HALTED; i_readM=1 only in FETCH; i_address=pc in every state.
REQ-019 In FETCH, with i_ready=1 and stall=0, the next edge SHALL load IF/ID {i_data, pc+1, valid=1}, set pc<=pc+1, and increment fetched_count.
REQ-020 In FETCH, with i_ready=1 and stall=1, the block SHALL capture i_data and pc+1 into a one-entry skid buffer, leave IF/ID unchanged, and enter HOLD.
REQ-021 In FETCH, with i_ready=0 and stall=0, the next edge SHALL clear if_id_valid (bubble) and keep pc; with i_ready=0 and stall=1, IF/ID SHALL hold.
REQ-022 In HOLD, while stall=1, IF/ID and the buffer SHALL hold; when stall=0, IF/ID SHALL load from the buffer with valid=1, pc<=pc+1, fetched_count increments, and the state returns to FETCH.
REQ-023 redirect=1 SHALL take priority over stall, halt, i_ready and the current state (HALTED included): the next edge sets pc<=redirect_pc, clears if_id_valid, discards the skid buffer, and enters FETCH.
REQ-024 halt=1 without redirect SHALL, on the next edge, enter HALTED and clear if_id_valid; HALTED is left only by reset or redirect.
REQ-025 pc+1 SHALL be 16-bit modular: 16'hFFFF increments to 16'h0000; fetched_count wraps the same way.
REQ-026 if_id_inst and if_id_pc_next SHALL keep their last values when if_id_valid is cleared; only the valid bit marks a bubble.

Reset
REQ-027 When reset_n=0, the block SHALL immediately set pc=0, state=FETCH, if_id_inst=0, if_id_pc_next=0, if_id_valid=0, fetched_count=0, and clear the skid buffer.
REQ-028 Reset during HOLD or HALTED SHALL discard all pending state, and i_readM SHALL be 1 from the first cycle after reset_n rises.

Structure
REQ-029 Word width (16), opcode/func field positions, and the FSM state encoding SHALL live in the shared opcodes package alongside the existing opcode definitions.
REQ-030 The one-entry skid buffer SHALL be a sub-module named fetch_skid_buffer (load, clear, data/pc storage, full flag).

Verification
REQ-031 Reset, then i_ready=1 every cycle with memory[n]=16'h6000+n -> IF/ID shows 16'h6000, 16'h6001, 16'h6002 on consecutive edges, with pc_next 1, 2, 3 and fetched_count 1, 2, 3.
REQ-032 Respond with i_data=16'h1234 and i_ready=1 while stall=1 for 3 cycles -> IF/ID is unchanged for 3 cycles, state is HOLD, and i_readM=0; on stall release, IF/ID shows 16'h1234 with valid=1 and pc has advanced by exactly 1.
REQ-033 Assert redirect=1 with redirect_pc=16'h0040 simultaneously with halt=1 and stall=1 -> the next cycle has if_id_valid=0, i_address=16'h0040, state FETCH, and the buffer is empty.
REQ-034 Assert halt at pc=16'h0005 -> from the next edge, i_readM=0 and if_id_valid=0 for 10 cycles, and fetched_count is frozen.
REQ-035 Force pc=16'hFFFF via redirect and return i_ready=1 -> if_id_pc_next=16'h0000 and the next i_address=16'h0000.
REQ-036 Assert reset_n=0 mid-cycle while in HOLD -> outputs clear without waiting for a clk edge, and i_readM=1 with i_address=0 after release.
